// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Moore sequencer for the 8-bit accumulator datapath. It fetches the opcode
// byte and, for LDAC/STAC/JUMP/JMPZ/JPNZ, the two address bytes (high byte
// first). It then drives every datapath select/enable needed to execute one of
// 16 instructions. It owns the architectural zero flag Z and parks in HALT on
// any opcode byte whose upper nibble is nonzero.
//
// All outputs come from flops. They are computed from the *next* state, so
// each output takes the value listed for a state on the same edge that enters
// that state. This keeps the outputs glitch-free and aligned with the state.
//
// Ports
//   clk      in   clock
//   reset    in   asynchronous, active-high reset
//   instr    in   [7:0] instruction register contents (opcode = instr[3:0])
//   zero     in   combinational ALU zero output
//   we       out  memory write enable
//   buff_ir  out  memdata -> IR latch enable
//   buff_ah  out  memdata -> address-high buffer latch enable
//   buff_al  out  memdata -> address-low buffer latch enable
//   buff_r   out  AC -> R latch enable
//   srcbmux  out  ALU B source: 0 = R, 1 = constant 1
//   adrmux   out  address source: 0 = PC, 1 = {adrH, adrL}
//   acmux    out  [1:0] AC source: 00 ALU, 01 memdata, 10 R
//   pcmux    out  [1:0] PC next: 00 hold, 01 PC+1, 10 {adrH, adrL}
//   aluop    out  [2:0] 000 pass ... 111 not
//   halted   out  high while in HALT
// -----------------------------------------------------------------------------
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       zero,
  output logic       we,
  output logic       buff_ir,
  output logic       buff_ah,
  output logic       buff_al,
  output logic       buff_r,
  output logic       srcbmux,
  output logic       adrmux,
  output logic [1:0] acmux,
  output logic [1:0] pcmux,
  output logic [2:0] aluop,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_FETCH_AH,
    S_FETCH_AL,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDAC = 4'h1,
    OP_STAC = 4'h2,
    OP_MVAC = 4'h3,
    OP_MOVR = 4'h4,
    OP_JUMP = 4'h5,
    OP_JMPZ = 4'h6,
    OP_JPNZ = 4'h7,
    OP_ADD  = 4'h8,
    OP_SUB  = 4'h9,
    OP_INAC = 4'hA,
    OP_CLAC = 4'hB,
    OP_AND  = 4'hC,
    OP_OR   = 4'hD,
    OP_XOR  = 4'hE,
    OP_NOT  = 4'hF
  } opcode_e;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_CLR  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_NOT  = 3'b111;

  localparam logic [1:0] AC_ALU = 2'b00;
  localparam logic [1:0] AC_MEM = 2'b01;
  localparam logic [1:0] AC_R   = 2'b10;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;

  typedef struct packed {
    logic       we;
    logic       buff_ir;
    logic       buff_ah;
    logic       buff_al;
    logic       buff_r;
    logic       srcbmux;
    logic       adrmux;
    logic [1:0] acmux;
    logic [1:0] pcmux;
    logic [2:0] aluop;
    logic       halted;
  } ctrl_t;

  // Defaults make AC reload its own value through the ALU pass path.
  localparam ctrl_t CTRL_IDLE = '{
    we: 1'b0, buff_ir: 1'b0, buff_ah: 1'b0, buff_al: 1'b0, buff_r: 1'b0,
    srcbmux: 1'b0, adrmux: 1'b0, acmux: AC_ALU, pcmux: PC_HOLD,
    aluop: ALU_PASS, halted: 1'b0
  };

  localparam ctrl_t CTRL_FETCH = '{
    we: 1'b0, buff_ir: 1'b1, buff_ah: 1'b0, buff_al: 1'b0, buff_r: 1'b0,
    srcbmux: 1'b0, adrmux: 1'b0, acmux: AC_ALU, pcmux: PC_INC,
    aluop: ALU_PASS, halted: 1'b0
  };

  state_e  state_q, state_d;
  logic    z_q, z_d;
  ctrl_t   ctrl_q, ctrl_d;

  opcode_e op;
  logic    illegal;
  logic    has_addr;
  logic    is_mem_op;
  logic    is_alu_op;
  logic    branch_taken;

  assign op        = opcode_e'(instr[3:0]);
  assign illegal   = |instr[7:4];
  assign has_addr  = op inside {OP_LDAC, OP_STAC, OP_JUMP, OP_JMPZ, OP_JPNZ};
  assign is_mem_op = op inside {OP_LDAC, OP_STAC};
  assign is_alu_op = instr[3];

  // The FETCH_AL outputs are computed while in FETCH_AH. Z can only change on
  // the edge that ends EXEC, so z_q here equals Z at the start of FETCH_AL.
  assign branch_taken = (op == OP_JUMP) ||
                        (op == OP_JMPZ &&  z_q) ||
                        (op == OP_JPNZ && !z_q);

  always_comb begin
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise a latch is inferred.
    state_d = state_q;
    z_d     = z_q;
    ctrl_d  = CTRL_IDLE;

    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        if (illegal)       state_d = S_HALT;
        else if (has_addr) state_d = S_FETCH_AH;
        else               state_d = S_EXEC;
      end
      S_FETCH_AH: state_d = S_FETCH_AL;
      S_FETCH_AL: state_d = is_mem_op ? S_MEM : S_FETCH;
      S_MEM:      state_d = S_FETCH;
      S_EXEC: begin
        state_d = S_FETCH;
        // Only the ALU group (8..F) updates Z; the ALU result is valid in EXEC.
        if (is_alu_op) z_d = zero;
      end
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase

    // Output decode for the state being entered.
    case (state_d)
      S_FETCH: ctrl_d = CTRL_FETCH;
      S_FETCH_AH: begin
        ctrl_d.buff_ah = 1'b1;
        ctrl_d.pcmux   = PC_INC;
      end
      S_FETCH_AL: begin
        ctrl_d.buff_al = 1'b1;
        ctrl_d.pcmux   = branch_taken ? PC_LOAD : PC_INC;
      end
      S_MEM: begin
        ctrl_d.adrmux = 1'b1;
        if (op == OP_STAC) ctrl_d.we    = 1'b1;     // writedata = AC via pass
        else               ctrl_d.acmux = AC_MEM;
      end
      S_EXEC: begin
        case (op)
          OP_MVAC: ctrl_d.buff_r = 1'b1;
          OP_MOVR: ctrl_d.acmux  = AC_R;
          OP_ADD:  ctrl_d.aluop  = ALU_ADD;
          OP_SUB:  ctrl_d.aluop  = ALU_SUB;
          OP_INAC: begin
            ctrl_d.aluop   = ALU_ADD;
            ctrl_d.srcbmux = 1'b1;
          end
          OP_CLAC: ctrl_d.aluop  = ALU_CLR;
          OP_AND:  ctrl_d.aluop  = ALU_AND;
          OP_OR:   ctrl_d.aluop  = ALU_OR;
          OP_XOR:  ctrl_d.aluop  = ALU_XOR;
          OP_NOT:  ctrl_d.aluop  = ALU_NOT;
          default: ctrl_d = CTRL_IDLE;
        endcase
      end
      S_HALT:  ctrl_d.halted = 1'b1;
      default: ctrl_d = CTRL_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      z_q     <= 1'b0;
      ctrl_q  <= CTRL_FETCH;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign we      = ctrl_q.we;
  assign buff_ir = ctrl_q.buff_ir;
  assign buff_ah = ctrl_q.buff_ah;
  assign buff_al = ctrl_q.buff_al;
  assign buff_r  = ctrl_q.buff_r;
  assign srcbmux = ctrl_q.srcbmux;
  assign adrmux  = ctrl_q.adrmux;
  assign acmux   = ctrl_q.acmux;
  assign pcmux   = ctrl_q.pcmux;
  assign aluop   = ctrl_q.aluop;
  assign halted  = ctrl_q.halted;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Wraps control_unit in a small accumulator datapath (PC, IR, adrH/adrL, AC,
// R, ALU, 64 KiB memory) so real programs can run. Expected values come from
// per-state output tables, hand-worked program results, and an instruction-
// level ISA model that steps whole instructions with plain arithmetic.
// Outputs are sampled on the falling edge; the DUT changes on the rising edge.
// -----------------------------------------------------------------------------
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] instr;
  logic       zero;
  logic       we, buff_ir, buff_ah, buff_al, buff_r, srcbmux, adrmux, halted;
  logic [1:0] acmux, pcmux;
  logic [2:0] aluop;

  control_unit dut (
    .clk    (clk),
    .reset  (reset),
    .instr  (instr),
    .zero   (zero),
    .we     (we),
    .buff_ir(buff_ir),
    .buff_ah(buff_ah),
    .buff_al(buff_al),
    .buff_r (buff_r),
    .srcbmux(srcbmux),
    .adrmux (adrmux),
    .acmux  (acmux),
    .pcmux  (pcmux),
    .aluop  (aluop),
    .halted (halted)
  );

  always #5 clk = ~clk;

  // ---------------- datapath environment ----------------
  logic [15:0] pc;
  logic [7:0]  ir, ah, al, ac, r;
  bit   [7:0]  dp_mem [0:65535];
  logic [15:0] addr;
  logic [7:0]  memdata, alu_b, alu_y;
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;

  assign instr   = ir;
  assign addr    = adrmux ? {ah, al} : pc;
  assign memdata = dp_mem[addr];
  assign alu_b   = srcbmux ? 8'd1 : r;
  assign zero    = (alu_y == 8'h00);

  always_comb begin
    case (aluop)
      3'b000:  alu_y = ac;
      3'b001:  alu_y = ac + alu_b;
      3'b010:  alu_y = ac - alu_b;
      3'b011:  alu_y = 8'h00;
      3'b100:  alu_y = ac & alu_b;
      3'b101:  alu_y = ac | alu_b;
      3'b110:  alu_y = ac ^ alu_b;
      default: alu_y = ~ac;
    endcase
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0; ir <= '0; ah <= '0; al <= '0; ac <= '0; r <= '0;
    end else begin
      if (buff_ir) ir <= memdata;
      if (buff_ah) ah <= memdata;
      if (buff_al) al <= memdata;
      if (buff_r)  r  <= ac;
      case (acmux)
        2'b00:   ac <= alu_y;
        2'b01:   ac <= memdata;
        2'b10:   ac <= r;
        default: ac <= ac;
      endcase
      // A jump in FETCH_AL takes the low byte straight from the bus.
      case (pcmux)
        2'b01:   pc <= pc + 16'd1;
        2'b10:   pc <= {ah, buff_al ? memdata : al};
        default: pc <= pc;
      endcase
    end
  end

  always @(posedge clk) begin
    if (ld_en)            dp_mem[ld_addr] <= ld_data;
    else if (we && !reset) dp_mem[addr]   <= alu_y;
  end

  // ---------------- ISA reference model ----------------
  bit   [7:0]  m_mem [0:65535];
  logic [15:0] m_pc;
  logic [7:0]  m_ac, m_r;
  logic        m_z;

  task automatic m_step(output int lat);
    logic [7:0]  op;
    logic [15:0] a;
    a    = '0;
    op   = m_mem[m_pc];
    m_pc = m_pc + 16'd1;
    lat  = 3;
    if (op[3:0] inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7}) begin
      a    = {m_mem[m_pc], m_mem[m_pc + 16'd1]};
      m_pc = m_pc + 16'd2;
      lat  = 4;
    end
    case (op[3:0])
      4'h1: begin m_ac = m_mem[a]; lat = 5; end
      4'h2: begin m_mem[a] = m_ac; lat = 5; end
      4'h3: m_r  = m_ac;
      4'h4: m_ac = m_r;
      4'h5: m_pc = a;
      4'h6: if (m_z)  m_pc = a;
      4'h7: if (!m_z) m_pc = a;
      4'h8: m_ac = m_ac + m_r;
      4'h9: m_ac = m_ac - m_r;
      4'hA: m_ac = m_ac + 8'd1;
      4'hB: m_ac = 8'h00;
      4'hC: m_ac = m_ac & m_r;
      4'hD: m_ac = m_ac | m_r;
      4'hE: m_ac = m_ac ^ m_r;
      4'hF: m_ac = ~m_ac;
      default: ;
    endcase
    if (op[3]) m_z = (m_ac == 8'h00);
  endtask

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] ctrl_now();
    return {we, buff_ir, buff_ah, buff_al, buff_r, srcbmux, adrmux, acmux, pcmux, aluop, halted};
  endfunction

  function automatic logic [14:0] mk(input logic we_, ir_, ah_, al_, r_, sb_, ad_,
                                     input logic [1:0] am_, pm_,
                                     input logic [2:0] op_, input logic h_);
    return {we_, ir_, ah_, al_, r_, sb_, ad_, am_, pm_, op_, h_};
  endfunction

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    m_mem[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_reset(input logic v);
    @(negedge clk);
    reset = v;
  endtask

  typedef struct {
    logic [7:0]        instr;
    logic              z;
    int                ncyc;
    logic [4:0][14:0]  exp;
    logic [14:0]       after;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] i, input logic z, input int n,
                     input logic [14:0] e0, e1, e2, e3, e4, aft);
    vec_t v;
    v.instr = i; v.z = z; v.ncyc = n; v.after = aft;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    vecs.push_back(v);
  endtask

  function automatic logic [14:0] ex(input logic [2:0] op, input logic sb);
    return mk(0, 0, 0, 0, 0, sb, 0, 2'b00, 2'b00, op, 0);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [14:0] w_f, w_d, w_ah, w_aln, w_alj, w_h, w_ld, w_st;
    int          we_cnt, we_idx;
    logic [15:0] we_addr;
    logic [7:0]  we_data;

    w_f   = mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0);
    w_d   = '0;
    w_ah  = mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0);
    w_aln = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0);
    w_alj = mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b10, 3'b000, 0);
    w_h   = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1);
    w_ld  = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 3'b000, 0);
    w_st  = mk(1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 0);

    add(8'h00, 0, 3, w_f, w_d, w_d, w_d, w_d, w_f);
    add(8'h03, 0, 3, w_f, w_d, mk(0,0,0,0,1,0,0,2'b00,2'b00,3'b000,0), w_d, w_d, w_f);
    add(8'h04, 0, 3, w_f, w_d, mk(0,0,0,0,0,0,0,2'b10,2'b00,3'b000,0), w_d, w_d, w_f);
    add(8'h08, 0, 3, w_f, w_d, ex(3'b001, 0), w_d, w_d, w_f);
    add(8'h09, 0, 3, w_f, w_d, ex(3'b010, 0), w_d, w_d, w_f);
    add(8'h0A, 0, 3, w_f, w_d, ex(3'b001, 1), w_d, w_d, w_f);
    add(8'h0B, 0, 3, w_f, w_d, ex(3'b011, 0), w_d, w_d, w_f);
    add(8'h0C, 0, 3, w_f, w_d, ex(3'b100, 0), w_d, w_d, w_f);
    add(8'h0D, 0, 3, w_f, w_d, ex(3'b101, 0), w_d, w_d, w_f);
    add(8'h0E, 0, 3, w_f, w_d, ex(3'b110, 0), w_d, w_d, w_f);
    add(8'h0F, 0, 3, w_f, w_d, ex(3'b111, 0), w_d, w_d, w_f);
    add(8'h01, 0, 5, w_f, w_d, w_ah, w_aln, w_ld, w_f);
    add(8'h02, 0, 5, w_f, w_d, w_ah, w_aln, w_st, w_f);
    add(8'h05, 0, 4, w_f, w_d, w_ah, w_alj, w_d, w_f);
    add(8'h05, 1, 4, w_f, w_d, w_ah, w_alj, w_d, w_f);
    add(8'h06, 0, 4, w_f, w_d, w_ah, w_aln, w_d, w_f);
    add(8'h06, 1, 4, w_f, w_d, w_ah, w_alj, w_d, w_f);
    add(8'h07, 0, 4, w_f, w_d, w_ah, w_alj, w_d, w_f);
    add(8'h07, 1, 4, w_f, w_d, w_ah, w_aln, w_d, w_f);
    add(8'h81, 0, 5, w_f, w_d, w_h, w_h, w_h, w_h);
    add(8'h40, 0, 5, w_f, w_d, w_h, w_h, w_h, w_h);

    // Reset state.
    @(negedge clk);
    check("reset_outputs", {17'd0, ctrl_now()}, {17'd0, w_f});

    // Per-state output tables; a CLAC preamble sets Z=1, a NOP keeps Z=0.
    foreach (vecs[i]) begin
      set_reset(1'b1);
      poke(16'h0000, vecs[i].z ? 8'h0B : 8'h00);
      poke(16'h0001, vecs[i].instr);
      poke(16'h0002, 8'h12);
      poke(16'h0003, 8'h34);
      set_reset(1'b0);
      repeat (3) @(negedge clk);
      for (int c = 0; c < vecs[i].ncyc; c++) begin
        check($sformatf("vec%0d_%02h_z%0d_cyc%0d", i, vecs[i].instr, vecs[i].z, c),
              {17'd0, ctrl_now()}, {17'd0, vecs[i].exp[c]});
        @(negedge clk);
      end
      check($sformatf("vec%0d_%02h_after", i, vecs[i].instr),
            {17'd0, ctrl_now()}, {17'd0, vecs[i].after});
    end

    // CLAC, INAC, MVAC, ADD -> AC=02, R=01, Z=0 (JMPZ not taken).
    set_reset(1'b1);
    poke(16'h0000, 8'h0B); poke(16'h0001, 8'h0A); poke(16'h0002, 8'h03);
    poke(16'h0003, 8'h08); poke(16'h0004, 8'h06); poke(16'h0005, 8'h00);
    poke(16'h0006, 8'h40);
    set_reset(1'b0);
    repeat (12) @(negedge clk);
    check("alu_seq_ac_r_pc", {8'd0, ac, r, pc[7:0]}, {8'd0, 8'h02, 8'h01, 8'h04});
    repeat (4) @(negedge clk);
    check("alu_seq_jmpz_pc", {16'd0, pc}, 32'h0007);

    // LDAC of 00 leaves Z=0 -> JMPZ not taken; after CLAC it is taken.
    set_reset(1'b1);
    poke(16'h0000, 8'h00); poke(16'h0001, 8'h01); poke(16'h0002, 8'h12);
    poke(16'h0003, 8'h34); poke(16'h0004, 8'h06); poke(16'h0005, 8'h00);
    poke(16'h0006, 8'h40); poke(16'h0007, 8'h0B); poke(16'h0008, 8'h06);
    poke(16'h0009, 8'h00); poke(16'h000A, 8'h40); poke(16'h1234, 8'h00);
    poke(16'h0040, 8'h00);
    set_reset(1'b0);
    repeat (12) @(negedge clk);
    check("ldac_jmpz_nt_ac", {24'd0, ac}, 32'h00);
    check("ldac_jmpz_nt_pc", {16'd0, pc}, 32'h0007);
    repeat (7) @(negedge clk);
    check("clac_jmpz_t_pc", {16'd0, pc}, 32'h0040);

    // STAC 00F0 with AC=5A: one we cycle, in MEM.
    set_reset(1'b1);
    poke(16'h0000, 8'h01); poke(16'h0001, 8'h80); poke(16'h0002, 8'h00);
    poke(16'h0003, 8'h02); poke(16'h0004, 8'h00); poke(16'h0005, 8'hF0);
    poke(16'h8000, 8'h5A); poke(16'h00F0, 8'h00);
    set_reset(1'b0);
    repeat (5) @(negedge clk);
    we_cnt = 0; we_idx = -1; we_addr = '0; we_data = '0;
    for (int c = 0; c < 5; c++) begin
      if (we) begin
        we_cnt++; we_idx = c; we_addr = addr; we_data = alu_y;
      end
      @(negedge clk);
    end
    check("stac_we_count", we_cnt, 1);
    check("stac_we_in_mem", we_idx, 4);
    check("stac_addr_data", {8'd0, we_addr, we_data}, {8'd0, 16'h00F0, 8'h5A});
    check("stac_pc", {16'd0, pc}, 32'h0006);
    check("stac_mem", {24'd0, dp_mem[16'h00F0]}, 32'h5A);

    // JPNZ with Z=0 taken; JUMP FFFF; next fetch wraps PC to 0000.
    set_reset(1'b1);
    poke(16'h0000, 8'h07); poke(16'h0001, 8'h12); poke(16'h0002, 8'h34);
    poke(16'h1234, 8'h05); poke(16'h1235, 8'hFF); poke(16'h1236, 8'hFF);
    poke(16'hFFFF, 8'h00);
    set_reset(1'b0);
    repeat (4) @(negedge clk);
    check("jpnz_pc", {16'd0, pc}, 32'h1234);
    repeat (4) @(negedge clk);
    check("jump_ffff_pc", {16'd0, pc}, 32'hFFFF);
    repeat (3) @(negedge clk);
    check("pc_wrap", {16'd0, pc}, 32'h0000);

    // Illegal 0x81 -> HALT for 10+ cycles; reset recovers.
    set_reset(1'b1);
    poke(16'h0000, 8'h81);
    set_reset(1'b0);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      check($sformatf("halt_cyc%0d", c), {17'd0, ctrl_now()}, {17'd0, w_h});
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("halt_reset_fetch", {17'd0, ctrl_now()}, {17'd0, w_f});
    set_reset(1'b0);
    @(negedge clk);
    check("halt_recover_decode", {17'd0, ctrl_now()}, {17'd0, w_d});

    // Reset in MEM of STAC: we drops at once, Z cleared (JMPZ not taken).
    set_reset(1'b1);
    poke(16'h0000, 8'h0B); poke(16'h0001, 8'h02); poke(16'h0002, 8'h00);
    poke(16'h0003, 8'hF0);
    set_reset(1'b0);
    repeat (7) @(negedge clk);
    check("mid_stac_we", {31'd0, we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_stac_reset_fetch", {17'd0, ctrl_now()}, {17'd0, w_f});
    poke(16'h0000, 8'h06); poke(16'h0001, 8'h00); poke(16'h0002, 8'h40);
    set_reset(1'b0);
    repeat (4) @(negedge clk);
    check("mid_stac_z_cleared", {16'd0, pc}, 32'h0003);

    // Random programs against the ISA model.
    for (int p = 0; p < 3; p++) begin
      int          ops[$];
      logic [15:0] starts[$];
      logic [15:0] a;
      logic [15:0] tgt;
      set_reset(1'b1);
      a = '0;
      for (int i = 0; i < 24; i++) begin
        int o;
        o = $urandom_range(0, 15);
        ops.push_back(o);
        starts.push_back(a);
        a = a + ((o inside {1, 2, 5, 6, 7}) ? 16'd3 : 16'd1);
      end
      a = '0;
      foreach (ops[i]) begin
        poke(a, 8'(ops[i]));
        a = a + 16'd1;
        if (ops[i] inside {1, 2, 5, 6, 7}) begin
          if (ops[i] inside {1, 2}) tgt = 16'h8000 + 16'($urandom_range(0, 15));
          else                      tgt = starts[$urandom_range(0, 23)];
          poke(a, tgt[15:8]);
          poke(a + 16'd1, tgt[7:0]);
          a = a + 16'd2;
        end
      end
      poke(a, 8'h05); poke(a + 16'd1, 8'h00); poke(a + 16'd2, 8'h00);
      for (int k = 0; k < 16; k++)
        poke(16'h8000 + 16'(k), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)));
      m_pc = '0; m_ac = '0; m_r = '0; m_z = 1'b0;
      set_reset(1'b0);
      for (int k = 0; k < 80; k++) begin
        int lat;
        m_step(lat);
        repeat (lat) @(negedge clk);
        check($sformatf("rand%0d_i%0d_boundary", p, k), {17'd0, ctrl_now()}, {17'd0, w_f});
        check($sformatf("rand%0d_i%0d_pc_ac_r", p, k), {pc, ac, r}, {m_pc, m_ac, m_r});
      end
      for (int k = 0; k < 16; k++)
        check($sformatf("rand%0d_mem%0d", p, k),
              {24'd0, dp_mem[16'h8000 + 16'(k)]}, {24'd0, m_mem[16'h8000 + 16'(k)]});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Moore state machine that sequences the 8-bit accumulator datapath. It fetches each instruction byte and, where needed, the two address bytes. It then drives every datapath select and enable (bus buffers, muxes, ALU op, memory write) to execute one of 16 instructions. It keeps the architectural zero flag Z and halts on illegal opcodes.

## Interface
- Parameters: none.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- instr  in  8  current instruction register contents
- zero  in  1  ALU zero output (combinational)
- we  out  1  memory write enable
- buff_ir, buff_ah, buff_al  out  1 each  latch enables: memdata into IR, address-high and address-low buffers
- buff_r  out  1  latch enable: AC into the R buffer
- srcbmux  out  1  ALU B source: 0 = R, 1 = constant 1
- adrmux  out  1  address source: 0 = PC, 1 = MDA
- acmux  out  2  AC source: 00 = ALU, 01 = memdata, 10 = R
- pcmux  out  2  PC next: 00 = hold, 01 = PC+1, 10 = {adrH, adrL}
- aluop  out  3  000 pass, 001 add, 010 sub, 011 clear, 100 and, 101 or, 110 xor, 111 not
- halted  out  1  high in HALT state

## Operation
- Opcode is instr[3:0]. instr[7:4] must be 0; a nonzero value is illegal.
- Opcode map: 0 NOP, 1 LDAC a, 2 STAC a, 3 MVAC (R<-AC), 4 MOVR (AC<-R), 5 JUMP a, 6 JMPZ a, 7 JPNZ a, 8 ADD, 9 SUB, A INAC, B CLAC, C AND, D OR, E XOR, F NOT. ALU ops 8–F use R as operand B; INAC uses constant 1.
- Address operand: two bytes following the opcode, high byte first.
- Default outputs (any signal not listed for a state): we=0, all buff_*=0, srcbmux=0, adrmux=0, acmux=00, pcmux=00, aluop=000. With these defaults AC reloads its own value, so AC holds.
- States and outputs:
  - FETCH: buff_ir=1, pcmux=01. Next state: DECODE.
  - DECODE: defaults only.
    - Next state HALT if instr[7:4]≠0.
    - Next state FETCH_AH for opcodes 1, 2, 5, 6, 7.
    - Next state EXEC otherwise.
  - FETCH_AH: buff_ah=1, pcmux=01. Next state: FETCH_AL.
  - FETCH_AL: buff_al=1.
    - pcmux=10 for JUMP, for JMPZ with Z=1, and for JPNZ with Z=0; pcmux=01 otherwise.
    - Next state MEM for LDAC/STAC; FETCH otherwise.
  - MEM: adrmux=1.
    - LDAC: acmux=01.
    - STAC: we=1, aluop=000 (writedata = AC).
    - Next state: FETCH.
  - EXEC: next state FETCH.
    - NOP: defaults.
    - MVAC: buff_r=1.
    - MOVR: acmux=10.
    - ALU ops: acmux=00 with the aluop above; srcbmux=1 only for INAC.
  - HALT: defaults, halted=1. Stays in HALT until reset.
- Z register:
  - Loads `zero` at the clock edge ending EXEC, for opcodes 8–F only.
  - All other instructions leave Z unchanged, including LDAC and MOVR.

## Timing
- Reset value: state=FETCH, Z=0, halted=0. Outputs are the FETCH values (buff_ir=1, pcmux=01, others default); this is harmless because the datapath registers are also held in reset.
- Reset mid-instruction: the instruction is abandoned immediately. The first cycle after reset release is FETCH.
- Latency per instruction:
  - 3 cycles: NOP, MVAC, MOVR, and ALU ops (FETCH, DECODE, EXEC).
  - 4 cycles: jumps, taken or not (… FETCH_AH, FETCH_AL).
  - 5 cycles: LDAC, STAC (… MEM).
- Branch decision uses Z as registered at the start of FETCH_AL. An ALU op immediately preceding a branch is visible to it.
- we is high for exactly one cycle per STAC. Address and data are stable for that whole cycle.
- Outputs depend on state, instr, and Z only. They are glitch-free relative to clk.

## Test plan
- Reset, then memory 00:0B (CLAC), 01:0A (INAC), 02:03 (MVAC), 03:08 (ADD) -> after 12 cycles AC=02, R=01, Z=0; per-state outputs match the Operation list.
- LDAC 0x1234 (bytes 01 12 34), memory[1234]=00, then JMPZ 0x0040 -> AC=00, Z unchanged by the load (was 0), so the branch is not taken and PC=0x0007. Repeat after CLAC -> taken, PC=0x0040.
- STAC 0x00F0 with AC=5A -> we high exactly one cycle in MEM, address=00F0, writedata=5A, PC=prior+3.
- JPNZ with Z=0 -> PC loads target in FETCH_AL. JUMP 0xFFFF -> PC=FFFF, and the next fetch PC+1 wraps to 0000.
- Illegal instruction byte 0x81 -> HALT after DECODE, halted=1, outputs default for ≥10 cycles. Reset -> FETCH, halted=0.
- Assert reset during MEM of STAC -> we drops immediately, state=FETCH, Z=0.
